// File: rtl/hazard_unit.sv
// Load-use stall and taken-branch flush controller for the 16-bit MIPS pipeline.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned LOAD_STALL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_IF_ID_rs,
  input  logic [2:0] in_IF_ID_rt,
  input  logic       in_IF_ID_uses_rt,
  input  logic       in_ID_EX_MemRead,
  input  logic [2:0] in_ID_EX_rt,
  input  logic       in_EX_Branch_taken,
  output logic       O_PC_Write,
  output logic       O_IF_ID_Write,
  output logic       O_IF_ID_Flush,
  output logic       O_ID_EX_Bubble,
  output logic [1:0] O_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] O_stall_cycles,
  output logic [15:0] O_flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01
  } state_t;

  localparam bit          MULTI_STALL = (LOAD_STALL > 1);
  localparam int unsigned REM_INIT_I  = (LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0;
  localparam logic [1:0]  REM_INIT    = REM_INIT_I[1:0];

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_rem;
  logic [1:0] w_next_rem;
  logic       w_hz;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_hz = in_ID_EX_MemRead && (in_ID_EX_rt != 3'd0) &&
                ((in_ID_EX_rt == in_IF_ID_rs) ||
                 (in_IF_ID_uses_rt && (in_ID_EX_rt == in_IF_ID_rt)));

  assign O_state = r_state;

  // Next-state and pipeline controls; reset and taken branch take priority.
  always_comb begin
    w_next_state   = r_state;
    w_next_rem     = r_rem;
    O_PC_Write     = 1'b1;
    O_IF_ID_Write  = 1'b1;
    O_IF_ID_Flush  = 1'b0;
    O_ID_EX_Bubble = 1'b0;
    if (!rst_n) begin
      O_PC_Write     = 1'b0;
      O_IF_ID_Write  = 1'b0;
      O_IF_ID_Flush  = 1'b1;
      O_ID_EX_Bubble = 1'b1;
      w_next_state   = ST_RUN;
      w_next_rem     = 2'd0;
    end else if (in_EX_Branch_taken) begin
      O_IF_ID_Flush  = 1'b1;
      O_ID_EX_Bubble = 1'b1;
      w_next_state   = ST_RUN;
      w_next_rem     = 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hz) begin
            O_PC_Write     = 1'b0;
            O_IF_ID_Write  = 1'b0;
            O_ID_EX_Bubble = 1'b1;
            if (MULTI_STALL) begin
              w_next_state = ST_STALL;
              w_next_rem   = REM_INIT;
            end else begin
              w_next_state = ST_RUN;
            end
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_STALL: begin
          O_PC_Write     = 1'b0;
          O_IF_ID_Write  = 1'b0;
          O_ID_EX_Bubble = 1'b1;
          if (r_rem == 2'd0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_rem = r_rem - 2'd1;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_rem   = 2'd0;
        end
      endcase
    end
  end

  // State and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_rem   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  assign O_stall_cycles = r_stall_cycles;
  assign O_flush_count  = r_flush_count;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (O_ID_EX_Bubble && !O_PC_Write && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (O_IF_ID_Flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: two hazard_unit instances (LOAD_STALL 2 and 3) share stimulus
// and are compared every cycle against a stall-budget reference model.
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] rs, rt, ex_rt;
  logic       uses_rt, mem_read, br;

  logic [1:0] pcw, ifw, fl, bub;
  logic [1:0] st2, st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc2, sc3, fc2, fc3;
`endif

  hazard_unit #(.LOAD_STALL(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_IF_ID_rs(rs), .in_IF_ID_rt(rt), .in_IF_ID_uses_rt(uses_rt),
    .in_ID_EX_MemRead(mem_read), .in_ID_EX_rt(ex_rt), .in_EX_Branch_taken(br),
    .O_PC_Write(pcw[0]), .O_IF_ID_Write(ifw[0]), .O_IF_ID_Flush(fl[0]),
    .O_ID_EX_Bubble(bub[0]), .O_state(st2)
`ifdef HAZARD_PERF_CNT_EN
    , .O_stall_cycles(sc2), .O_flush_count(fc2)
`endif
  );

  hazard_unit #(.LOAD_STALL(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_IF_ID_rs(rs), .in_IF_ID_rt(rt), .in_IF_ID_uses_rt(uses_rt),
    .in_ID_EX_MemRead(mem_read), .in_ID_EX_rt(ex_rt), .in_EX_Branch_taken(br),
    .O_PC_Write(pcw[1]), .O_IF_ID_Write(ifw[1]), .O_IF_ID_Flush(fl[1]),
    .O_ID_EX_Bubble(bub[1]), .O_state(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .O_stall_cycles(sc3), .O_flush_count(fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ls[2]        = '{2, 3};
  int left[2]      = '{0, 0};
  int cnt_stall[2] = '{0, 0};
  int cnt_flush[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hz();
    return mem_read && (ex_rt != 3'd0) &&
           ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  endfunction

  // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  function automatic logic [3:0] model_ctl(input int k);
    if (!rst_n)             return 4'b0011;
    if (br)                 return 4'b1111;
    if (left[k] > 0 || model_hz()) return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic check_now(input string pfx);
    logic [3:0] got;
    logic [1:0] sts[2];
    sts[0] = st2;
    sts[1] = st3;
    for (int k = 0; k < 2; k++) begin
      got = {pcw[k], ifw[k], fl[k], bub[k]};
      chk($sformatf("%s_ctl_ls%0d", pfx, ls[k]), {28'd0, got}, {28'd0, model_ctl(k)});
      chk($sformatf("%s_state_ls%0d", pfx, ls[k]), {30'd0, sts[k]},
          (left[k] > 0) ? 32'd1 : 32'd0);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk({pfx, "_stallcnt_ls2"}, {16'd0, sc2}, cnt_stall[0]);
    chk({pfx, "_stallcnt_ls3"}, {16'd0, sc3}, cnt_stall[1]);
    chk({pfx, "_flushcnt_ls2"}, {16'd0, fc2}, cnt_flush[0]);
    chk({pfx, "_flushcnt_ls3"}, {16'd0, fc3}, cnt_flush[1]);
`endif
  endtask

  // One pipeline cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input string tag, input logic m, input logic [2:0] e_rt,
                      input logic [2:0] s_rs, input logic [2:0] s_rt,
                      input logic u, input logic b);
    logic [3:0] e[2];
    mem_read = m; ex_rt = e_rt; rs = s_rs; rt = s_rt; uses_rt = u; br = b;
    @(negedge clk);
    check_now(tag);
    for (int k = 0; k < 2; k++) e[k] = model_ctl(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (e[k][0] && !e[k][3] && cnt_stall[k] < 65535) cnt_stall[k]++;
      if (e[k][1] && cnt_flush[k] < 65535) cnt_flush[k]++;
      if (b)                left[k] = 0;
      else if (left[k] > 0) left[k]--;
      else if (model_hz())  left[k] = ls[k] - 1;
    end
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = 0; cnt_stall[k] = 0; cnt_flush[k] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; ex_rt = 3'd0; rs = 3'd0; rt = 3'd0; uses_rt = 1'b0; br = 1'b0;
    model_reset();
    #3;
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load r3 with dependent rs=3: 2-cycle / 3-cycle stall, then release
    step("lu_c1", 1'b1, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0);
    step("lu_c2", 1'b1, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0);
    step("lu_c3", 1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0);
    step("lu_c4", 1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0);
    step("lu_c5", 1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0);

    // r0 never hazards
    step("r0_a", 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    step("r0_b", 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);

    // rt match only counts when the instruction reads rt
    step("rt_nouse", 1'b1, 3'd5, 3'd2, 3'd5, 1'b0, 1'b0);
    step("rt_use1", 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b0);
    step("rt_use2", 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b0);
    step("rt_use3", 1'b0, 3'd0, 3'd2, 3'd5, 1'b1, 1'b0);
    step("rt_use4", 1'b0, 3'd0, 3'd2, 3'd5, 1'b1, 1'b0);

    // Branch taken in a later stall cycle abandons the stall
    step("br_c1", 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0);
    step("br_c2", 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0);
    step("br_c3", 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1);
    step("br_c4", 1'b0, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0);

    // Branch and hazard together: flush only
    step("brhz_a", 1'b1, 3'd6, 3'd6, 3'd0, 1'b0, 1'b1);
    step("brhz_b", 1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0);

    // Back-to-back hazards
    for (int i = 0; i < 7; i++)
      step("b2b", 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);

    // Reset pulse mid-stall
    step("pre_rst", 1'b1, 3'd7, 3'd1, 3'd7, 1'b1, 1'b0);
    mem_read = 1'b0; br = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now("async_rst");
    @(posedge clk);
    #1;
    check_now("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now("rst_release");
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 16-bit, 8-register MIPS core. It reads the ID/EX pipeline register's load flag and destination field, together with the source fields of the instruction in IF/ID, and drives the write enables and bubble/flush controls back into the PC, IF/ID and ID/EX. It inserts load-use stalls of configurable length and flushes wrong-path instructions when EX resolves a taken branch.

## Interface
- LOAD_STALL, 2, stall cycles per load-use hazard; legal range 1..4.
- clk  in  1  pipeline clock; rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_IF_ID_rs  in  3  rs field of the instruction in IF/ID.
- in_IF_ID_rt  in  3  rt field of the instruction in IF/ID.
- in_IF_ID_uses_rt  in  1  instruction in IF/ID reads rt (R-type, store, branch).
- in_ID_EX_MemRead  in  1  instruction in ID/EX is a load.
- in_ID_EX_rt  in  3  load destination register in ID/EX.
- in_EX_Branch_taken  in  1  branch in EX resolved taken this cycle.
- O_PC_Write  out  1  PC load enable.
- O_IF_ID_Write  out  1  IF/ID load enable.
- O_IF_ID_Flush  out  1  IF/ID loads a NOP.
- O_ID_EX_Bubble  out  1  ID/EX loads all-zero control signals.
- O_state  out  2  FSM state: 00 RUN, 01 STALL.
- O_stall_cycles  out  16  stall cycle count; present only with HAZARD_PERF_CNT_EN.
- O_flush_count  out  16  taken-branch flush count; present only with HAZARD_PERF_CNT_EN.

## Operation
- Hazard detect `hz` = in_ID_EX_MemRead && in_ID_EX_rt != 0 && (in_ID_EX_rt == in_IF_ID_rs || (in_IF_ID_uses_rt && in_ID_EX_rt == in_IF_ID_rt)). Register 0 never hazards.
- State register and a 2-bit countdown `rem`.
- In RUN with branch taken:
  - PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1.
  - Stay in RUN. Branch overrides `hz`.
- In RUN with `hz` and no branch:
  - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1.
  - If LOAD_STALL>1: go to STALL, rem=LOAD_STALL-2. Otherwise stay in RUN.
- In RUN with neither: PC_Write=1, IF_ID_Write=1, Flush=0, Bubble=0.
- In STALL without branch:
  - Same outputs as a RUN hazard. `hz` is not evaluated.
  - When rem==0, go to RUN; otherwise decrement rem.
- In STALL with branch taken:
  - Branch outputs as in RUN.
  - Go to RUN and clear rem. The stall is abandoned.

## Timing
- All four control outputs are combinational from inputs and state, and are valid in the same cycle as detection.
- A load-use hazard stalls PC and IF/ID for exactly LOAD_STALL consecutive cycles. The dependent instruction enters ID/EX on the following edge.
- Back-to-back hazards: a new hazard on the first RUN cycle after a stall starts a fresh stall with no gap.
- While rst_n is low:
  - State=RUN, rem=0.
  - Outputs forced to PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1. This holds the pipeline cleared.
  - Counters are 0.
- Reset asserted mid-stall aborts the stall immediately. After release, the first cycle is RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - O_stall_cycles increments on every cycle with ID_EX_Bubble=1 and PC_Write=0.
  - O_flush_count increments on every cycle with IF_ID_Flush=1 while rst_n is high.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: both ports and both counters are absent.

## Test plan
- LOAD_STALL=2; load writing r3 in ID/EX, IF/ID rs=3 -> PC_Write=0 and Bubble=1 for exactly 2 cycles, O_state 00->01->00, then PC_Write=1.
- Load writing r0 with IF/ID rs=0 -> no stall, PC_Write=1 throughout.
- in_IF_ID_uses_rt=0, rt=5 matching load rt=5, rs=2 -> no stall. Same with uses_rt=1 -> stall.
- LOAD_STALL=3; branch taken in the second STALL cycle -> that cycle Flush=1, Bubble=1, PC_Write=1; next cycle O_state=00.
- Branch taken and `hz` together in RUN -> flush outputs only, no stall. With HAZARD_PERF_CNT_EN, O_flush_count=1 and O_stall_cycles=0.
- rst_n low for 1 cycle mid-stall -> outputs 0/0/1/1 asynchronously, state RUN after release, counters 0.
